// File: rtl/axi_slice_pkg.sv
// Shared AXI slice definitions: burst encodings, 4 KB page constant, FSM state type
// and the beats-to-page-end helper used by the AR burst splitter.
package axi_slice_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int BOUNDARY_4K = 4096;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  // addr must already be size-aligned, so the shift divides exactly.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input logic [2:0] size);
    logic [12:0] w_bytes;
    w_bytes = 13'(BOUNDARY_4K) - {1'b0, addr};
    return w_bytes >> size;
  endfunction

endpackage

// File: rtl/axi_ar_split_calc.sv
// Combinational sub-burst sizing: beats in the next sub-burst, whether it is the
// final one, and the aligned start address of the sub-burst after it.
module axi_ar_split_calc
  import axi_slice_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  input  logic [8:0]            i_rem,
  output logic [8:0]            o_beats,
  output logic [7:0]            o_len,
  output logic                  o_last,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic                  w_incr;
  logic [ADDR_WIDTH-1:0] w_aligned;
  logic [12:0]           w_to_4k;
  logic [12:0]           w_lim;
  logic [12:0]           w_rem;
  logic [12:0]           w_beats;

  assign w_incr    = (i_burst == BURST_INCR);
  assign w_aligned = i_addr & ({ADDR_WIDTH{1'b1}} << i_size);
  assign w_to_4k   = beats_to_4k(w_aligned[11:0], i_size);
  assign w_lim     = (w_to_4k < 13'(MAX_BEATS)) ? w_to_4k : 13'(MAX_BEATS);
  assign w_rem     = {4'd0, i_rem};

  // Non-INCR bursts are never split: the whole request is one sub-burst.
  assign w_beats     = (!w_incr || (w_rem <= w_lim)) ? w_rem : w_lim;
  assign o_beats     = w_beats[8:0];
  assign o_len       = 8'(w_beats - 13'd1);
  assign o_last      = (w_beats == w_rem);
  assign o_next_addr = w_aligned + (ADDR_WIDTH'(w_beats) << i_size);

endmodule

// File: rtl/axi_ar_burst_splitter.sv
// AR-channel burst splitter: re-issues each INCR request as sub-bursts of at most
// MAX_BEATS beats that never cross a 4 KB page; FIXED/WRAP pass through whole.
module axi_ar_burst_splitter
  import axi_slice_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_valid_i,
  output logic                  slave_ready_o,
  input  logic [ADDR_WIDTH-1:0] slave_addr_i,
  input  logic [2:0]            slave_prot_i,
  input  logic [3:0]            slave_region_i,
  input  logic [7:0]            slave_len_i,
  input  logic [2:0]            slave_size_i,
  input  logic [1:0]            slave_burst_i,
  input  logic                  slave_lock_i,
  input  logic [3:0]            slave_cache_i,
  input  logic [3:0]            slave_qos_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  output logic                  master_valid_o,
  input  logic                  master_ready_i,
  output logic [ADDR_WIDTH-1:0] master_addr_o,
  output logic [2:0]            master_prot_o,
  output logic [3:0]            master_region_o,
  output logic [7:0]            master_len_o,
  output logic [2:0]            master_size_o,
  output logic [1:0]            master_burst_o,
  output logic                  master_lock_o,
  output logic [3:0]            master_cache_o,
  output logic [3:0]            master_qos_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_split_last_o
);

  localparam int FW = ID_WIDTH + USER_WIDTH + 21;

  ar_state_e             r_state, w_state_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [ADDR_WIDTH-1:0] r_m_addr, w_m_addr_nxt;
  logic [7:0]            r_m_len, w_m_len_nxt;
  logic                  r_m_last, w_m_last_nxt;
  logic [FW-1:0]         r_fields, w_fields_nxt;
  logic [ADDR_WIDTH-1:0] r_cur, w_cur_nxt;
  logic [8:0]            r_rem, w_rem_nxt;

  logic [ADDR_WIDTH-1:0] w_calc_addr, w_calc_next;
  logic [2:0]            w_calc_size;
  logic [1:0]            w_calc_burst;
  logic [8:0]            w_calc_rem, w_sub_beats;
  logic [7:0]            w_sub_len;
  logic                  w_sub_last;

  axi_ar_split_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_BEATS  (MAX_BEATS)
  ) u_calc (
    .i_addr      (w_calc_addr),
    .i_size      (w_calc_size),
    .i_burst     (w_calc_burst),
    .i_rem       (w_calc_rem),
    .o_beats     (w_sub_beats),
    .o_len       (w_sub_len),
    .o_last      (w_sub_last),
    .o_next_addr (w_calc_next)
  );

  assign slave_ready_o       = (r_state == IDLE);
  assign master_valid_o      = r_valid;
  assign master_addr_o       = r_m_addr;
  assign master_len_o        = r_m_len;
  assign master_split_last_o = r_m_last;
  assign {master_id_o, master_user_o, master_prot_o, master_region_o, master_size_o,
          master_burst_o, master_lock_o, master_cache_o, master_qos_o} = r_fields;

  // r_cur/r_rem always describe the sub-burst that follows the one on the outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_valid;
    w_m_addr_nxt = r_m_addr;
    w_m_len_nxt  = r_m_len;
    w_m_last_nxt = r_m_last;
    w_fields_nxt = r_fields;
    w_cur_nxt    = r_cur;
    w_rem_nxt    = r_rem;
    w_calc_addr  = r_cur;
    w_calc_rem   = r_rem;
    w_calc_size  = master_size_o;
    w_calc_burst = master_burst_o;
    case (r_state)
      IDLE: begin
        w_calc_addr  = slave_addr_i;
        w_calc_rem   = {1'b0, slave_len_i} + 9'd1;
        w_calc_size  = slave_size_i;
        w_calc_burst = slave_burst_i;
        if (slave_valid_i) begin
          w_state_nxt  = ISSUE;
          w_valid_nxt  = 1'b1;
          w_m_addr_nxt = slave_addr_i;
          w_m_len_nxt  = w_sub_len;
          w_m_last_nxt = w_sub_last;
          w_fields_nxt = {slave_id_i, slave_user_i, slave_prot_i, slave_region_i, slave_size_i,
                          slave_burst_i, slave_lock_i, slave_cache_i, slave_qos_i};
          w_cur_nxt    = w_calc_next;
          w_rem_nxt    = w_calc_rem - w_sub_beats;
        end
      end
      ISSUE: begin
        if (master_ready_i) begin
          if (r_m_last) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end else begin
            w_m_addr_nxt = r_cur;
            w_m_len_nxt  = w_sub_len;
            w_m_last_nxt = w_sub_last;
            w_cur_nxt    = w_calc_next;
            w_rem_nxt    = r_rem - w_sub_beats;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_m_addr <= '0;
      r_m_len  <= '0;
      r_m_last <= 1'b0;
      r_fields <= '0;
      r_cur    <= '0;
      r_rem    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_valid  <= w_valid_nxt;
      r_m_addr <= w_m_addr_nxt;
      r_m_len  <= w_m_len_nxt;
      r_m_last <= w_m_last_nxt;
      r_fields <= w_fields_nxt;
      r_cur    <= w_cur_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

endmodule

// File: tb/tb_axi_ar_burst_splitter.sv
// Scoreboard bench for axi_ar_burst_splitter: a beat-level reference model queues the
// expected sub-bursts and a negedge monitor pops and compares on every master handshake.
module tb_axi_ar_burst_splitter;

  localparam int MAX_BEATS = 16;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
    logic [30:0] f;
  } exp_t;

  logic        clk_i, rst_ni;
  logic        slave_valid_i, slave_ready_o;
  logic [31:0] slave_addr_i;
  logic [2:0]  slave_prot_i;
  logic [3:0]  slave_region_i;
  logic [7:0]  slave_len_i;
  logic [2:0]  slave_size_i;
  logic [1:0]  slave_burst_i;
  logic        slave_lock_i;
  logic [3:0]  slave_cache_i, slave_qos_i, slave_id_i;
  logic [5:0]  slave_user_i;
  logic        master_valid_o, master_ready_i;
  logic [31:0] master_addr_o;
  logic [2:0]  master_prot_o;
  logic [3:0]  master_region_o;
  logic [7:0]  master_len_o;
  logic [2:0]  master_size_o;
  logic [1:0]  master_burst_o;
  logic        master_lock_o;
  logic [3:0]  master_cache_o, master_qos_o, master_id_o;
  logic [5:0]  master_user_o;
  logic        master_split_last_o;

  axi_ar_burst_splitter #(.ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6), .MAX_BEATS(MAX_BEATS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slave_valid_i(slave_valid_i), .slave_ready_o(slave_ready_o),
    .slave_addr_i(slave_addr_i), .slave_prot_i(slave_prot_i), .slave_region_i(slave_region_i),
    .slave_len_i(slave_len_i), .slave_size_i(slave_size_i), .slave_burst_i(slave_burst_i),
    .slave_lock_i(slave_lock_i), .slave_cache_i(slave_cache_i), .slave_qos_i(slave_qos_i),
    .slave_id_i(slave_id_i), .slave_user_i(slave_user_i),
    .master_valid_o(master_valid_o), .master_ready_i(master_ready_i),
    .master_addr_o(master_addr_o), .master_prot_o(master_prot_o), .master_region_o(master_region_o),
    .master_len_o(master_len_o), .master_size_o(master_size_o), .master_burst_o(master_burst_o),
    .master_lock_o(master_lock_o), .master_cache_o(master_cache_o), .master_qos_o(master_qos_o),
    .master_id_o(master_id_o), .master_user_o(master_user_o),
    .master_split_last_o(master_split_last_o)
  );

  exp_t exp_q[$];
  int   n_cmp = 0, n_mis = 0;
  int   cyc = 0, acc_cyc = 0;
  bit   rdy_rand = 0, rdy_val = 1;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: walk the beats of the original burst and close a sub-burst
  // whenever it is full or the next beat lands on a different 4 KB page.
  task automatic model_push(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input logic [30:0] f);
    exp_t        e;
    int          n, st;
    logic [31:0] a0, b, bs;
    n = int'(len) + 1;
    st = 0;
    e.f = f;
    if (bu != 2'b01) begin
      e.addr = a; e.len = len; e.last = 1'b1;
      exp_q.push_back(e);
      return;
    end
    a0 = a & ~((32'd1 << sz) - 32'd1);
    for (int k = 1; k <= n; k++) begin
      bs = a0 + (32'(st) << sz);
      b  = a0 + (32'(k) << sz);
      if (k == n || (k - st) == MAX_BEATS || b[31:12] != bs[31:12]) begin
        e.addr = (st == 0) ? a : bs;
        e.len  = 8'(k - st - 1);
        e.last = (k == n);
        exp_q.push_back(e);
        st = k;
      end
    end
  endtask

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                      input logic [1:0] bu);
    int t = 0;
    slave_addr_i   = a;
    slave_len_i    = len;
    slave_size_i   = sz;
    slave_burst_i  = bu;
    slave_prot_i   = 3'($urandom);
    slave_region_i = 4'($urandom);
    slave_lock_i   = 1'($urandom);
    slave_cache_i  = 4'($urandom);
    slave_qos_i    = 4'($urandom);
    slave_id_i     = 4'($urandom);
    slave_user_i   = 6'($urandom);
    slave_valid_i  = 1'b1;
    @(negedge clk_i);
    while (!slave_ready_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    if (!slave_ready_o) begin
      chk("accept_timeout", slave_ready_o, 1);
    end else begin
      acc_cyc = cyc;
      model_push(a, len, sz, bu, {slave_id_i, slave_user_i, slave_prot_i, slave_region_i,
                 slave_size_i, slave_burst_i, slave_lock_i, slave_cache_i, slave_qos_i});
    end
    @(posedge clk_i);
    #1;
    slave_valid_i = 1'b0;
  endtask

  initial begin
    master_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      master_ready_i = rdy_rand ? ($urandom_range(3) != 0) : rdy_val;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t         e;
    bit           prev_stall = 0, prev_valid = 0;
    logic [71:0]  cur, saved = '0;
    logic [30:0]  fo;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 0;
        prev_valid = 0;
      end else begin
        fo  = {master_id_o, master_user_o, master_prot_o, master_region_o, master_size_o,
               master_burst_o, master_lock_o, master_cache_o, master_qos_o};
        cur = {master_addr_o, master_len_o, master_split_last_o, fo};
        if (prev_stall) chk("stall_hold", {master_valid_o, cur}, {1'b1, saved});
        if (master_valid_o) begin
          chk("slave_ready_busy", slave_ready_o, 0);
          if (!prev_valid) chk("accept_latency", cyc - acc_cyc, 1);
          if (master_ready_i) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_sub", master_valid_o, 0);
            end else begin
              e = exp_q.pop_front();
              chk("sub_addr", master_addr_o, e.addr);
              chk("sub_len", master_len_o, e.len);
              chk("sub_last", master_split_last_o, e.last);
              chk("sub_fields", fo, e.f);
            end
          end
        end
        prev_stall = master_valid_o && !master_ready_i;
        prev_valid = master_valid_o;
        saved      = cur;
      end
    end
  end

  initial begin
    int n, a1, a2, t;
    logic [31:0] ra;
    rst_ni = 1'b0;
    slave_valid_i = 0; slave_addr_i = 0; slave_len_i = 0; slave_size_i = 0; slave_burst_i = 0;
    slave_prot_i = 0; slave_region_i = 0; slave_lock_i = 0; slave_cache_i = 0; slave_qos_i = 0;
    slave_id_i = 0; slave_user_i = 0;
    #3;
    chk("rst_valid", master_valid_o, 0);
    chk("rst_addr", master_addr_o, 0);
    chk("rst_len", master_len_o, 0);
    chk("rst_last", master_split_last_o, 0);
    chk("rst_id", master_id_o, 0);
    chk("rst_slave_ready", slave_ready_o, 1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    sync();

    // 64-beat INCR across a 4 KB page: four sub-bursts, four busy cycles
    rdy_val = 1;
    send(32'h0000_0F80, 8'd63, 3'd3, 2'b01);
    n = 0;
    @(negedge clk_i);
    while (!slave_ready_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    chk("busy_cycles", n, 4);
    sync();

    send(32'h0000_0FFC, 8'd3, 3'd2, 2'b01);
    send(32'h0000_0100, 8'd15, 3'd2, 2'b10);

    // stall the second sub-burst for five cycles
    send(32'h0000_0F80, 8'd63, 3'd3, 2'b01);
    sync();
    rdy_val = 0;
    repeat (5) sync();
    rdy_val = 1;

    // back-to-back single sub-bursts: one bubble between acceptances
    send($urandom, 8'd0, 3'd2, 2'b01);
    a1 = acc_cyc;
    send($urandom, 8'd7, 3'd2, 2'b00);
    a2 = acc_cyc;
    chk("b2b_gap", a2 - a1, 2);

    // reset in the middle of a long burst
    repeat (3) sync();
    rdy_val = 0;
    send(32'h0000_0F80, 8'd63, 3'd3, 2'b01);
    repeat (2) sync();
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", master_valid_o, 0);
    chk("midrst_addr", master_addr_o, 0);
    chk("midrst_last", master_split_last_o, 0);
    exp_q.delete();
    sync();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("postrst_slave_ready", slave_ready_o, 1);
    sync();
    rdy_val = 1;
    send(32'h0000_2468, 8'd0, 3'd2, 2'b01);

    // randomized traffic with random backpressure
    rdy_rand = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(2))
        0: ra = {20'($urandom), 4'hF, 8'($urandom)};
        1: ra = {20'hFFFFF, 12'($urandom)};
        default: ra = $urandom;
      endcase
      send(ra, ($urandom_range(1) != 0) ? 8'($urandom_range(20)) : 8'($urandom),
           3'($urandom), 2'($urandom));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      sync();
      t++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (3) sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
